// File: rtl/axi4_stream_mult_slave_if.sv
// Stream bundle for the multiplier: inbound operand beats, outbound result beats and status.
// The slave modport is the multiplier's view; the master modport is the surrounding system's view.
interface axi4_stream_mult_slave_if #(
    parameter int DSZ = 8
);
    logic [DSZ-1:0] tdata_to_slave;
    logic           tvalid_to_slave;
    logic           tready_to_slave;
    logic           tlast_to_slave;
    logic [DSZ-1:0] tdata_to_master;
    logic           tvalid_to_master;
    logic           tready_to_master;
    logic           tlast_to_master;
    logic           frame_err;
    logic           busy;

    modport slave (
        input  tdata_to_slave, tvalid_to_slave, tlast_to_slave, tready_to_master,
        output tready_to_slave, tdata_to_master, tvalid_to_master, tlast_to_master,
        output frame_err, busy
    );

    modport master (
        output tdata_to_slave, tvalid_to_slave, tlast_to_slave, tready_to_master,
        input  tready_to_slave, tdata_to_master, tvalid_to_master, tlast_to_master,
        input  frame_err, busy
    );
endinterface

// File: rtl/axi4_stream_mult_slave.sv
// Receives two SZ-bit operands as a stream frame, multiplies them with a shift-add loop,
// and streams the 2*SZ-bit product back out LSB beat first.
module axi4_stream_mult_slave #(
    parameter int SZ  = 32,
    parameter int DSZ = 8
) (
    input  logic                           clk,
    input  logic                           _rst,
    axi4_stream_mult_slave_if.slave        s,
    output logic [1:0]                     o_dbg_state
);
    localparam int NB    = SZ / DSZ;
    localparam int NBEAT = 2 * NB;
    localparam int IW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int CW    = $clog2(SZ + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBEAT - 1);
    localparam logic [IW-1:0] B_START  = IW'(NB);
    localparam logic [CW-1:0] MUL_DONE = CW'(SZ);

    typedef enum logic [1:0] {
        RECV = 2'd0,
        MUL  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_widx;
    logic [IW-1:0]   r_oidx;
    logic [CW-1:0]   r_cnt;
    logic [SZ-1:0]   r_a;
    logic [SZ-1:0]   r_b;
    logic [2*SZ-1:0] r_res;
    logic            r_tready;
    logic            r_tvalid;
    logic            r_tlast;
    logic [DSZ-1:0]  r_tdata;
    logic            r_frame_err;
    logic            r_busy;

    logic [SZ-1:0]   w_a_nxt;
    logic [SZ-1:0]   w_b_nxt;
    logic [SZ:0]     w_sum;
    logic [IW-1:0]   w_pos;
    logic [IW-1:0]   w_oidx_nxt;
    logic            w_in_hs;
    logic            w_in_last;
    logic            w_short;
    logic            w_mul_step;
    logic            w_mul_done;
    logic            w_out_hs;
    logic            w_out_last;

    // Handshake: a beat moves on a rising edge where valid and ready are both high;
    // a raised valid keeps its data and last flag unchanged until that edge.
    always_comb begin
        w_in_hs    = r_tready && s.tvalid_to_slave;
        w_in_last  = w_in_hs && (r_widx == LAST_IDX);
        w_short    = w_in_hs && s.tlast_to_slave && (r_widx != LAST_IDX);
        w_mul_step = (r_state == MUL) && (r_cnt != MUL_DONE);
        w_mul_done = (r_state == MUL) && (r_cnt == MUL_DONE);
        w_out_hs   = r_tvalid && s.tready_to_master;
        w_out_last = w_out_hs && (r_oidx == LAST_IDX);
        w_oidx_nxt = r_oidx + IW'(1);

        // Beat position inside whichever operand the current index belongs to.
        w_pos   = (r_widx >= B_START) ? (r_widx - B_START) : r_widx;
        w_a_nxt = r_a;
        w_b_nxt = r_b;
        if (r_widx < B_START) begin
            w_a_nxt[int'(w_pos)*DSZ +: DSZ] = s.tdata_to_slave;
        end else begin
            w_b_nxt[int'(w_pos)*DSZ +: DSZ] = s.tdata_to_slave;
        end

        // r_res = {partial, remaining multiplier}: add a when the multiplier LSB is set, shift right.
        w_sum = {1'b0, r_res[2*SZ-1:SZ]} + (r_res[0] ? {1'b0, r_a} : {(SZ+1){1'b0}});

        w_state_nxt = r_state;
        unique case (r_state)
            RECV:    if (w_in_last)  w_state_nxt = MUL;
            MUL:     if (w_mul_done) w_state_nxt = SEND;
            SEND:    if (w_out_last) w_state_nxt = RECV;
            default: w_state_nxt = RECV;
        endcase
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_state <= RECV;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_widx      <= '0;
            r_oidx      <= '0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_tready    <= 1'b1;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tdata     <= '0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_tready    <= (w_state_nxt == RECV);
            r_busy      <= (w_state_nxt != RECV);
            r_frame_err <= w_short;

            if (w_in_hs) begin
                r_a <= w_a_nxt;
                r_b <= w_b_nxt;
                if (w_in_last || s.tlast_to_slave) begin
                    r_widx <= '0;
                end else begin
                    r_widx <= r_widx + IW'(1);
                end
            end

            if (w_in_last) begin
                r_res <= {{SZ{1'b0}}, w_b_nxt};
                r_cnt <= '0;
            end else if (w_mul_step) begin
                r_res <= {w_sum, r_res[SZ-1:1]};
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_mul_done) begin
                r_tvalid <= 1'b1;
                r_tlast  <= 1'b0;
                r_tdata  <= r_res[DSZ-1:0];
                r_oidx   <= '0;
            end else if (w_out_hs) begin
                if (r_oidx == LAST_IDX) begin
                    r_tvalid <= 1'b0;
                    r_tlast  <= 1'b0;
                    r_tdata  <= '0;
                    r_oidx   <= '0;
                end else begin
                    r_oidx  <= w_oidx_nxt;
                    r_tdata <= r_res[int'(w_oidx_nxt)*DSZ +: DSZ];
                    r_tlast <= (w_oidx_nxt == LAST_IDX);
                end
            end
        end
    end

    assign s.tready_to_slave  = r_tready;
    assign s.tvalid_to_master = r_tvalid;
    assign s.tlast_to_master  = r_tlast;
    assign s.tdata_to_master  = r_tdata;
    assign s.frame_err        = r_frame_err;
    assign s.busy             = r_busy;
    assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_axi4_stream_mult_slave.sv
// Bench for the stream multiplier: directed spec cases plus randomized frames, all results
// predicted from plain 64-bit multiplication of the operands sent.
module tb_axi4_stream_mult_slave;
    localparam int SZ    = 32;
    localparam int DSZ   = 8;
    localparam int NBEAT = 8;
    localparam int LAT   = SZ + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  dbg_state;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          accept_edge = 0;
    logic [63:0] exp_q[$];

    axi4_stream_mult_slave_if #(.DSZ(DSZ)) bus();

    axi4_stream_mult_slave #(.SZ(SZ), .DSZ(DSZ)) dut (
        .clk         (clk),
        ._rst        (rst_n),
        .s           (bus),
        .o_dbg_state (dbg_state)
    );

    // Clock and reset infrastructure
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: one operand frame, LSB byte of a first; stops early after a tlast beat.
    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input int last_at,
                              input int max_gap, output int ok);
        logic [63:0] beats;
        beats = {b, a};
        ok = 1;
        for (int i = 0; i < NBEAT; i++) begin
            int g;
            int n;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            bus.tvalid_to_slave = 1'b0;
            repeat (g) @(negedge clk);
            bus.tdata_to_slave  = beats[i*8 +: 8];
            bus.tlast_to_slave  = (i == last_at);
            bus.tvalid_to_slave = 1'b1;
            n = 0;
            while (bus.tready_to_slave !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                ok = 0;
                break;
            end
            if (i == NBEAT - 1 || i == last_at) accept_edge = cyc + 1;
            @(negedge clk);
            if (i == last_at) break;
        end
        bus.tvalid_to_slave = 1'b0;
        bus.tlast_to_slave  = 1'b0;
    endtask

    // Receiver: mode 0 ready always, 1 ready toggling, 2 ready random.
    task automatic collect(input int mode, output logic [63:0] got, output int nbeats,
                           output logic [7:0] lasts, output int hold_err, output int first_edge,
                           output int slv_rdy, output int timed_out);
        logic [7:0] prev_d;
        logic       prev_l;
        logic       prev_stall;
        int         n;
        got = '0; nbeats = 0; lasts = '0; hold_err = 0; first_edge = -1; slv_rdy = 0;
        prev_d = '0; prev_l = 1'b0; prev_stall = 1'b0; n = 0;
        while (nbeats < NBEAT && n < 400) begin
            case (mode)
                0:       bus.tready_to_master = 1'b1;
                1:       bus.tready_to_master = (n % 2 == 0);
                default: bus.tready_to_master = 1'($urandom_range(1, 0));
            endcase
            if (bus.tvalid_to_master === 1'b1) begin
                if (first_edge < 0) first_edge = cyc;
                if (prev_stall && (bus.tdata_to_master !== prev_d || bus.tlast_to_master !== prev_l))
                    hold_err++;
                if (bus.tready_to_master) begin
                    got[nbeats*8 +: 8] = bus.tdata_to_master;
                    lasts[nbeats]      = bus.tlast_to_master;
                    nbeats++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_d     = bus.tdata_to_master;
                    prev_l     = bus.tlast_to_master;
                end
            end else begin
                if (prev_stall) hold_err++;
                prev_stall = 1'b0;
            end
            if (bus.tready_to_slave === 1'b1) slv_rdy++;
            @(negedge clk);
            n++;
        end
        timed_out = (nbeats < NBEAT) ? 1 : 0;
        bus.tready_to_master = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.tready_to_slave !== 1'b1 || bus.tvalid_to_master !== 1'b0 || bus.tlast_to_master !== 1'b0)
            begin n_err++; $display("FAIL reset_hs got rdy=%b vld=%b last=%b exp 1 0 0", bus.tready_to_slave, bus.tvalid_to_master, bus.tlast_to_master); end
        n_cmp++; if (bus.tdata_to_master !== 8'h00 || bus.frame_err !== 1'b0 || bus.busy !== 1'b0)
            begin n_err++; $display("FAIL reset_out got data=%h err=%b busy=%b exp 00 0 0", bus.tdata_to_master, bus.frame_err, bus.busy); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.tready_to_slave !== 1'b1 || bus.busy !== 1'b0 || bus.tvalid_to_master !== 1'b0)
            begin n_err++; $display("FAIL reset_idle got rdy=%b busy=%b vld=%b exp 1 0 0", bus.tready_to_slave, bus.busy, bus.tvalid_to_master); end
    endtask

    task automatic test_basic();
        logic [63:0] got, exp;
        logic [7:0]  lasts;
        int nb, he, fe, sr, to, ok;
        exp_q.push_back(64'(32'd3) * 64'(32'd5));
        send_frame(32'd3, 32'd5, 7, 0, ok);
        n_cmp++; if (ok != 1) begin n_err++; $display("FAIL basic_send got timeout exp accepted"); end
        n_cmp++; if (bus.busy !== 1'b1 || bus.tready_to_slave !== 1'b0)
            begin n_err++; $display("FAIL basic_busy got busy=%b rdy=%b exp 1 0", bus.busy, bus.tready_to_slave); end
        collect(0, got, nb, lasts, he, fe, sr, to);
        exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL basic_data got=%h exp=%h", got, exp); end
        n_cmp++; if (got !== 64'h0F) begin n_err++; $display("FAIL basic_const got=%h exp=%h", got, 64'h0F); end
        n_cmp++; if (lasts !== 8'h80) begin n_err++; $display("FAIL basic_tlast got=%b exp=%b", lasts, 8'h80); end
        n_cmp++; if (fe - accept_edge != LAT) begin n_err++; $display("FAIL basic_latency got=%0d exp=%0d", fe - accept_edge, LAT); end
        n_cmp++; if (bus.tvalid_to_master !== 1'b0 || bus.tlast_to_master !== 1'b0 || bus.busy !== 1'b0)
            begin n_err++; $display("FAIL basic_drop got vld=%b last=%b busy=%b exp 0 0 0", bus.tvalid_to_master, bus.tlast_to_master, bus.busy); end
    endtask

    task automatic test_max();
        logic [63:0] got, exp;
        logic [7:0]  lasts;
        int nb, he, fe, sr, to, ok;
        exp_q.push_back(64'(32'hFFFF_FFFF) * 64'(32'hFFFF_FFFF));
        send_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 1, ok);
        collect(0, got, nb, lasts, he, fe, sr, to);
        exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL max_data got=%h exp=%h", got, exp); end
        n_cmp++; if (lasts !== 8'h80) begin n_err++; $display("FAIL max_tlast got=%b exp=%b", lasts, 8'h80); end
    endtask

    task automatic test_stall();
        logic [63:0] got, exp;
        logic [7:0]  lasts;
        int nb, he, fe, sr, to, ok;
        exp_q.push_back(64'(32'h1234_5678) * 64'(32'h9ABC_DEF0));
        send_frame(32'h1234_5678, 32'h9ABC_DEF0, 7, 0, ok);
        collect(1, got, nb, lasts, he, fe, sr, to);
        exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL stall_data got=%h exp=%h", got, exp); end
        n_cmp++; if (he != 0) begin n_err++; $display("FAIL stall_hold got=%0d exp=0", he); end
        n_cmp++; if (nb != NBEAT || lasts !== 8'h80) begin n_err++; $display("FAIL stall_beats got=%0d/%b exp=8/%b", nb, lasts, 8'h80); end
        n_cmp++; if (fe - accept_edge != LAT) begin n_err++; $display("FAIL stall_latency got=%0d exp=%0d", fe - accept_edge, LAT); end
    endtask

    task automatic test_short_frame();
        logic [63:0] got, exp;
        logic [7:0]  lasts;
        int nb, he, fe, sr, to, ok, seen;
        send_frame(32'hAABB_CCDD, 32'h1122_3344, 4, 0, ok);
        n_cmp++; if (bus.frame_err !== 1'b1) begin n_err++; $display("FAIL short_err_on got=%b exp=1", bus.frame_err); end
        @(negedge clk);
        n_cmp++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL short_err_off got=%b exp=0", bus.frame_err); end
        n_cmp++; if (bus.tready_to_slave !== 1'b1 || bus.busy !== 1'b0)
            begin n_err++; $display("FAIL short_state got rdy=%b busy=%b exp 1 0", bus.tready_to_slave, bus.busy); end
        seen = 0;
        bus.tready_to_master = 1'b1;
        repeat (40) begin
            if (bus.tvalid_to_master === 1'b1 || bus.frame_err === 1'b1) seen++;
            @(negedge clk);
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL short_quiet got=%0d exp=0", seen); end
        exp_q.push_back(64'(32'd2) * 64'(32'd7));
        send_frame(32'd2, 32'd7, 7, 0, ok);
        collect(0, got, nb, lasts, he, fe, sr, to);
        exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL short_next got=%h exp=%h", got, exp); end
    endtask

    task automatic test_reset_mid_mul();
        logic [63:0] got, exp;
        logic [7:0]  lasts;
        int nb, he, fe, sr, to, ok, seen;
        send_frame(32'hDEAD_BEEF, 32'h0000_1234, 7, 0, ok);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.tvalid_to_master !== 1'b0 || bus.tready_to_slave !== 1'b1 || bus.busy !== 1'b0)
            begin n_err++; $display("FAIL rstmul_now got vld=%b rdy=%b busy=%b exp 0 1 0", bus.tvalid_to_master, bus.tready_to_slave, bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        bus.tready_to_master = 1'b1;
        repeat (60) begin
            if (bus.tvalid_to_master === 1'b1) seen++;
            @(negedge clk);
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rstmul_quiet got=%0d exp=0", seen); end
        exp_q.push_back(64'(32'd11) * 64'(32'd13));
        send_frame(32'd11, 32'd13, 7, 0, ok);
        collect(0, got, nb, lasts, he, fe, sr, to);
        exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rstmul_next got=%h exp=%h", got, exp); end
    endtask

    task automatic test_reset_mid_send();
        int ok, n, seen;
        send_frame(32'h0101_0101, 32'h0202_0202, 7, 0, ok);
        bus.tready_to_master = 1'b0;
        n = 0;
        while (bus.tvalid_to_master !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (n >= 100) begin n_err++; $display("FAIL rstsend_wait got timeout exp valid"); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.tvalid_to_master !== 1'b0 || bus.tdata_to_master !== 8'h00 || bus.tready_to_slave !== 1'b1)
            begin n_err++; $display("FAIL rstsend_now got vld=%b data=%h rdy=%b exp 0 00 1", bus.tvalid_to_master, bus.tdata_to_master, bus.tready_to_slave); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.tready_to_master = 1'b1;
        seen = 0;
        repeat (40) begin
            if (bus.tvalid_to_master === 1'b1) seen++;
            @(negedge clk);
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rstsend_quiet got=%0d exp=0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] got, exp;
        logic [7:0]  lasts;
        int nb, he, fe, sr, to, ok;
        exp_q.push_back(64'(32'h0000_F00D) * 64'(32'h0003_0005));
        exp_q.push_back(64'(32'h7654_3210) * 64'(32'h0000_00FF));
        send_frame(32'h0000_F00D, 32'h0003_0005, 7, 0, ok);
        bus.tdata_to_slave  = 8'h10;
        bus.tlast_to_slave  = 1'b0;
        bus.tvalid_to_slave = 1'b1;
        collect(0, got, nb, lasts, he, fe, sr, to);
        exp = exp_q.pop_front();
        n_cmp++; if (sr != 0) begin n_err++; $display("FAIL b2b_ready_low got=%0d exp=0", sr); end
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL b2b_first got=%h exp=%h", got, exp); end
        n_cmp++; if (bus.tready_to_slave !== 1'b1) begin n_err++; $display("FAIL b2b_reopen got=%b exp=1", bus.tready_to_slave); end
        send_frame(32'h7654_3210, 32'h0000_00FF, 7, 0, ok);
        collect(2, got, nb, lasts, he, fe, sr, to);
        exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL b2b_second got=%h exp=%h", got, exp); end
    endtask

    task automatic test_random();
        logic [63:0] got, exp;
        logic [7:0]  lasts;
        logic [31:0] a, b;
        int nb, he, fe, sr, to, ok;
        for (int k = 0; k < 6; k++) begin
            case ($urandom_range(3, 0))
                0:       a = 32'h0;
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            b = $urandom;
            exp_q.push_back(64'(a) * 64'(b));
            send_frame(a, b, 7, 2, ok);
            collect(2, got, nb, lasts, he, fe, sr, to);
            exp = exp_q.pop_front();
            n_cmp++; if (to != 0 || got !== exp) begin n_err++; $display("FAIL rand_data[%0d] got=%h exp=%h", k, got, exp); end
            n_cmp++; if (lasts !== 8'h80 || he != 0) begin n_err++; $display("FAIL rand_ctrl[%0d] got tlast=%b hold=%0d exp %b 0", k, lasts, he, 8'h80); end
            n_cmp++; if (fe - accept_edge != LAT) begin n_err++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", k, fe - accept_edge, LAT); end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        bus.tdata_to_slave   = '0;
        bus.tvalid_to_slave  = 1'b0;
        bus.tlast_to_slave   = 1'b0;
        bus.tready_to_master = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_max();
        test_stall();
        test_short_frame();
        test_reset_mid_mul();
        test_reset_mid_send();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
